// File: rtl/imem_responder_pkg.sv
// Shared constants for the instruction-memory responder.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
// Contents: the NOP word, the 1-bit LOAD/RUN state encoding, default sizing
// and a byte-lane insert helper used by the boot packer.
package imem_responder_pkg;

    localparam int unsigned DEFAULT_ADDR_W     = 10;
    localparam int unsigned DEFAULT_LOAD_WORDS = 256;

    // addi x0,x0,0 -- driven whenever no valid array word is being served
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // FSM encoding kept as plain constants so older tools can consume it
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Return word with byte lane 'lane' replaced by 'b' (little-endian lanes)
    function automatic logic [31:0] insert_byte(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [7:0]  b
    );
        logic [31:0] w_res;
        w_res                      = word;
        w_res[{lane, 3'b000} +: 8] = b;
        return w_res;
    endfunction

endpackage

// File: rtl/imem_responder_byte_packer.sv
// Boot byte packer: gathers little-endian bytes into 32-bit words.
// Latency: word strobe is combinational with the accepting byte (same cycle).
// Backpressure: none of its own; the parent gates i_accept with load_ready.
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_accept           a boot byte is taken this cycle
//   i_byte, i_last     byte value and final-byte flag
//   o_word             packed word (unfilled upper lanes are zero)
//   o_word_vld         o_word must be written this cycle
//   o_last_word        the word being written ends the image
module imem_byte_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_word_vld,
    output logic        o_last_word
);
    import imem_responder_pkg::*;

    logic [1:0]  r_lane;
    logic [31:0] r_pack;
    logic [31:0] w_merged;
    logic        w_emit;

    // The incoming byte is merged in-flight so the word can be written in the
    // same cycle the lane-3 (or last) byte arrives. Lanes above r_lane are
    // still zero because the pack register is cleared after every emit.
    always_comb begin
        w_merged = insert_byte(r_pack, r_lane, i_byte);
    end

    assign w_emit      = i_accept && ((r_lane == 2'd3) || i_last);
    assign o_word      = w_merged;
    assign o_word_vld  = w_emit;
    assign o_last_word = w_emit && i_last;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lane <= 2'd0;
            r_pack <= 32'd0;
        end else if (w_emit) begin
            r_lane <= 2'd0;
            r_pack <= 32'd0;
        end else if (i_accept) begin
            r_lane <= r_lane + 2'd1;
            r_pack <= w_merged;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: boot-loads a byte image, then serves fetch.
// Latency: one cycle, registered, from address to o_instruction_out.
// Backpressure: o_load_ready gates boot bytes; fetch waits on o_mem_ready,
//   i_stall holds the output, i_flush replaces the next output with a NOP.
// Optional: define IMEM_MISALIGN_CHECK_EN to add o_misaligned, which flags
//   reads whose low address bits are non-zero and returns a NOP for them.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_instruction_address     byte address from fetch ([1:0] not used to index)
//   i_stall, i_flush          hold output / force NOP on next output
//   o_instruction_out         registered instruction word
//   i_load_valid/_byte/_last  boot byte stream, o_load_ready accepts it
//   o_mem_ready               image loaded, fetch may advance
//   o_misaligned              (IMEM_MISALIGN_CHECK_EN only) misaligned read flag
module imem_responder #(
    parameter int unsigned ADDR_W     = imem_responder_pkg::DEFAULT_ADDR_W,
    parameter int unsigned LOAD_WORDS = imem_responder_pkg::DEFAULT_LOAD_WORDS,
    parameter logic [31:0] NOP_WORD   = imem_responder_pkg::NOP_WORD
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_instruction_address,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [31:0]       o_instruction_out,
    input  logic              i_load_valid,
    input  logic [7:0]        i_load_byte,
    input  logic              i_load_last,
    output logic              o_load_ready,
    output logic              o_mem_ready
`ifdef IMEM_MISALIGN_CHECK_EN
    ,
    output logic              o_misaligned
`endif
);
    import imem_responder_pkg::*;

    localparam int unsigned       IDX_W    = ADDR_W - 2;
    localparam int unsigned       DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0]  LAST_PTR = IDX_W'(LOAD_WORDS - 1);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_wr_ptr;
    logic             r_load_ready;
    logic [31:0]      r_instr;
    logic [31:0]      r_mem [DEPTH];

    logic             w_accept;
    logic [31:0]      w_word;
    logic             w_word_vld;
    logic             w_last_word;
    logic             w_done;
    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] w_rd_idx;
    logic [31:0]      w_rd_word;
    logic             w_mis;

    // ---------------------------------------------------------------
    // Boot path
    // ---------------------------------------------------------------
    assign w_accept = i_load_valid && r_load_ready && (r_state == ST_LOAD);

    imem_byte_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_accept    (w_accept),
        .i_byte      (i_load_byte),
        .i_last      (i_load_last),
        .o_word      (w_word),
        .o_word_vld  (w_word_vld),
        .o_last_word (w_last_word)
    );

    // Loading ends on the word carrying the last byte, or on the write to
    // the final slot even if the image never flags a last byte.
    assign w_done      = w_word_vld && (w_last_word || (r_wr_ptr == LAST_PTR));
    assign w_state_nxt = ((r_state == ST_LOAD) && w_done) ? ST_RUN : r_state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_LOAD;
            r_wr_ptr     <= '0;
            r_load_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            // Registered so it drops in the same cycle mem_ready rises.
            r_load_ready <= (w_state_nxt == ST_LOAD);
            if (w_word_vld) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Word array: one write port (boot) and one read port (run). The two
    // phases never overlap, so no read/write collision handling is needed.
    // No reset here so the array maps onto block RAM.
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_word_vld) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    assign w_rd_idx  = i_instruction_address[ADDR_W-1:2];
    assign w_rd_word = r_mem[w_rd_idx];

    // ---------------------------------------------------------------
    // Read output register
    // ---------------------------------------------------------------
`ifdef IMEM_MISALIGN_CHECK_EN
    logic r_mis;

    assign w_mis = (i_instruction_address[1:0] != 2'b00);

    // Tracks r_instr exactly: stall holds it, flush and non-run clear it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mis <= 1'b0;
        end else if (r_state != ST_RUN) begin
            r_mis <= 1'b0;
        end else if (i_flush) begin
            r_mis <= 1'b0;
        end else if (!i_stall) begin
            r_mis <= w_mis;
        end
    end

    assign o_misaligned = r_mis;
`else
    // Low address bits are deliberately ignored in this build.
    logic w_unused_addr_lo;

    assign w_unused_addr_lo = ^i_instruction_address[1:0];
    assign w_mis            = 1'b0;
`endif

    // Flush takes priority over stall; a misaligned read returns a NOP.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_instr <= NOP_WORD;
        end else if (r_state != ST_RUN) begin
            r_instr <= NOP_WORD;
        end else if (i_flush) begin
            r_instr <= NOP_WORD;
        end else if (!i_stall) begin
            r_instr <= w_mis ? NOP_WORD : w_rd_word;
        end
    end

    assign o_instruction_out = r_instr;
    assign o_load_ready      = r_load_ready;
    assign o_mem_ready       = (r_state == ST_RUN);

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: boot-loads images, then checks fetch reads.
// Latency: reads are expected one cycle after the address is driven.
// Backpressure: boot bytes wait (bounded) for load_ready before being taken.
`timescale 1ns/1ps
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int ADDR_W     = 10;
    localparam int LOAD_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic              stall;
    logic              flush;
    logic [31:0]       instr;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_last;
    logic              load_ready;
    logic              mem_ready;
`ifdef IMEM_MISALIGN_CHECK_EN
    logic              misaligned;
`endif

    always #5 clk = ~clk;

    imem_responder #(
        .ADDR_W     (ADDR_W),
        .LOAD_WORDS (LOAD_WORDS),
        .NOP_WORD   (32'h0000_0013)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_instruction_address (addr),
        .i_stall               (stall),
        .i_flush               (flush),
        .o_instruction_out     (instr),
        .i_load_valid          (load_valid),
        .i_load_byte           (load_byte),
        .i_load_last           (load_last),
        .o_load_ready          (load_ready),
        .o_mem_ready           (mem_ready)
`ifdef IMEM_MISALIGN_CHECK_EN
        ,
        .o_misaligned          (misaligned)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model of the array and output register
    logic [31:0] m_mem [LOAD_WORDS];
    logic [31:0] m_pack;
    int          m_lane;
    int          m_ptr;
    logic [31:0] m_out;
    logic        m_mis;
    logic [32:0] sb_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        tick();
        tick();
        check_val("rst_instr", instr, 32'h0000_0013);
        check_val("rst_load_ready", {31'd0, load_ready}, 32'd0);
        check_val("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_load_ready", {31'd0, load_ready}, 32'd1);
        m_lane = 0;
        m_pack = 32'd0;
        m_ptr  = 0;
        m_out  = NOP_WORD;
        m_mis  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int  waited;
        bit  done;
        waited     = 0;
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        while (!load_ready && waited < 10) begin
            tick();
            waited++;
        end
        if (!load_ready) begin
            check_val("load_ready_timeout", {31'd0, load_ready}, 32'd1);
            load_valid = 1'b0;
            load_last  = 1'b0;
            return;
        end
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        done       = 1'b0;
        m_pack[m_lane*8 +: 8] = b;
        if (m_lane == 3 || last) begin
            m_mem[m_ptr] = m_pack;
            done         = last || (m_ptr == LOAD_WORDS - 1);
            m_ptr        = (m_ptr + 1) % LOAD_WORDS;
            m_lane       = 0;
            m_pack       = 32'd0;
        end else begin
            m_lane++;
        end
        check_val("mem_ready_after_byte", {31'd0, mem_ready}, {31'd0, done});
        if (done) check_val("load_ready_in_run", {31'd0, load_ready}, 32'd0);
    endtask

    // Bytes are taken LSB first from 'bytes'
    task automatic load_seq(input logic [63:0] bytes, input int n, input logic last_at_end);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = bytes[8*k +: 8];
            send_byte(b, (k == n - 1) ? last_at_end : 1'b0);
        end
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic st, input logic fl);
        logic [32:0] e;
        logic        mis;
        addr  = a;
        stall = st;
        flush = fl;
`ifdef IMEM_MISALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (fl) begin
            m_out = NOP_WORD;
            m_mis = 1'b0;
        end else if (!st) begin
            m_mis = mis;
            m_out = mis ? NOP_WORD : m_mem[a[ADDR_W-1:2]];
        end
        sb_q.push_back({m_mis, m_out});
        tick();
        e = sb_q.pop_front();
        check_val($sformatf("rd_%h_s%0d_f%0d", a, st, fl), instr, e[31:0]);
`ifdef IMEM_MISALIGN_CHECK_EN
        check_val($sformatf("mis_%h", a), {31'd0, misaligned}, {31'd0, e[32]});
`endif
        stall = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [63:0] wb;
        rst_n      = 1'b0;
        addr       = '0;
        stall      = 1'b0;
        flush      = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'd0;
        load_last  = 1'b0;

        // Basic two-word image
        do_reset();
        addr = 10'h004;
        tick();
        check_val("load_phase_nop", instr, 32'h0000_0013);
        load_seq(64'h0010_0593_0000_0513, 8, 1'b1);
        rd(10'h004, 1'b0, 1'b0);
        check_val("tp1_word1", instr, 32'h0010_0593);
        rd(10'h000, 1'b0, 1'b0);
        check_val("tp1_word0", instr, 32'h0000_0513);

        // Stall holds while the address moves
        rd(10'h000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rd(10'h004, 1'b1, 1'b0);
        check_val("stall_hold", instr, 32'h0000_0513);
        rd(10'h004, 1'b0, 1'b0);

        // Flush overrides stall, then reads resume
        rd(10'h000, 1'b1, 1'b1);
        check_val("flush_nop", instr, 32'h0000_0013);
        rd(10'h000, 1'b0, 1'b0);
        rd(10'h004, 1'b0, 1'b1);
        rd(10'h004, 1'b0, 1'b0);

        // Bytes offered in RUN are ignored
        load_valid = 1'b1;
        load_byte  = 8'hFF;
        load_last  = 1'b1;
        tick();
        tick();
        check_val("run_load_ready", {31'd0, load_ready}, 32'd0);
        check_val("run_mem_ready", {31'd0, mem_ready}, 32'd1);
        load_valid = 1'b0;
        load_last  = 1'b0;
        rd(10'h000, 1'b0, 1'b0);

        // Reset mid-word, then reload a single word
        do_reset();
        load_seq(64'h0000_0000_0000_BBAA, 2, 1'b0);
        check_val("midload_mem_ready", {31'd0, mem_ready}, 32'd0);
        do_reset();
        m_mem[0] = 32'h0;
        load_seq(64'h0000_0000_4433_2211, 4, 1'b1);
        rd(10'h000, 1'b0, 1'b0);
        check_val("reload_word0", instr, 32'h4433_2211);
        rd(10'h004, 1'b0, 1'b0);

        // Five-byte image: partial last word zero-filled
        do_reset();
        load_seq(64'h0000_00EE_DDCC_BBAA, 5, 1'b1);
        rd(10'h004, 1'b0, 1'b0);
        check_val("partial_word", instr, 32'h0000_00EE);
        rd(10'h000, 1'b0, 1'b0);

        // Full image without a last flag: RUN after the final slot
        do_reset();
        for (int i = 0; i < LOAD_WORDS; i++) begin
            w  = (i * 32'h0101_0101) ^ 32'hA500_5A00;
            wb = {32'd0, w};
            load_seq(wb, 4, 1'b0);
        end
        check_val("full_mem_ready", {31'd0, mem_ready}, 32'd1);
        rd(10'h000, 1'b0, 1'b0);
        rd(10'h3FC, 1'b0, 1'b0);
        check_val("full_last_word", instr, (32'd255 * 32'h0101_0101) ^ 32'hA500_5A00);
        rd(10'h200, 1'b0, 1'b0);
        rd(10'h008, 1'b0, 1'b0);

`ifdef IMEM_MISALIGN_CHECK_EN
        rd(10'h006, 1'b0, 1'b0);
        check_val("mis_set", {31'd0, misaligned}, 32'd1);
        rd(10'h008, 1'b1, 1'b0);
        rd(10'h008, 1'b0, 1'b0);
        check_val("mis_clear", {31'd0, misaligned}, 32'd0);
        rd(10'h003, 1'b0, 1'b0);
        rd(10'h008, 1'b1, 1'b1);
        rd(10'h00C, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
